// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter2
// Description : Two-master Wishbone arbiter in front of one shared slave.
//               Grants alternate on a tie. A granted master keeps the bus
//               while its cyc is high. A watchdog ends a strobe that the
//               slave never acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter2 #(
  parameter int TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        arst_i,
  // master 0
  input  logic [4:0]  m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1
  input  logic [4:0]  m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared slave
  output logic [4:0]  s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_last;     // 1 = master 1 held the most recent grant
  logic        r_kill;     // suppresses the strobe in the cycle after a timeout
  logic [7:0]  r_cnt;      // cycles the current strobe has waited for ack
  logic        w_timeout;

  // Read data is broadcast; only the granted master sees an ack.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Next grant: hold while the owner's cyc is high, otherwise hand over.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_next = r_last ? GNT0 : GNT1;
        else if (m0_cyc_i)        w_next = GNT0;
        else if (m1_cyc_i)        w_next = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) w_next = m1_cyc_i ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!m1_cyc_i) w_next = m0_cyc_i ? GNT0 : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Slave-side mux and per-master ack and err routing.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (r_state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i && !r_kill;
        m0_ack_o = s_ack_i;
        m0_err_o = w_timeout;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i && !r_kill;
        m1_ack_o = s_ack_i;
        m1_err_o = w_timeout;
      end
      default: ;
    endcase
  end

  // An ack arriving in the final wait cycle takes priority over the timeout.
  assign w_timeout = (r_state != IDLE) && s_stb_o && !s_ack_i && (r_cnt == C_CNT_LAST);

  // Grant state, fairness bit, wait counter and post-timeout strobe kill.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == GNT0 && r_state != GNT0) r_last <= 1'b0;
      else if (w_next == GNT1 && r_state != GNT1) r_last <= 1'b1;
      if (r_state == IDLE || s_ack_i || !s_stb_o || w_timeout) r_cnt <= '0;
      else r_cnt <= r_cnt + 8'd1;
      r_kill <= w_timeout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter2
// Description : Directed self-checking bench for wb_arbiter2. One instance
//               uses TIMEOUT=16 and a second uses TIMEOUT=4. Both instances
//               share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        arst_i;
  logic [4:0]  m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [4:0]  s_adr_o;
  logic        s_we_o, s_stb_o, s_cyc_o;

  logic [31:0] b_m0_dat_o, b_m1_dat_o, b_s_dat_o;
  logic        b_m0_ack_o, b_m0_err_o, b_m1_ack_o, b_m1_err_o;
  logic [4:0]  b_s_adr_o;
  logic        b_s_we_o, b_s_stb_o, b_s_cyc_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT(16)) dut (
    .wb_clk_i(clk), .arst_i(arst_i),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
    .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  wb_arbiter2 #(.TIMEOUT(4)) dut4 (
    .wb_clk_i(clk), .arst_i(arst_i),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(b_m0_dat_o), .m0_we_i(m0_we),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(b_m0_ack_o), .m0_err_o(b_m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(b_m1_dat_o), .m1_we_i(m1_we),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(b_m1_ack_o), .m1_err_o(b_m1_err_o),
    .s_adr_o(b_s_adr_o), .s_dat_o(b_s_dat_o), .s_we_o(b_s_we_o), .s_stb_o(b_s_stb_o),
    .s_cyc_o(b_s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    s_ack_i = 0;
  endtask

  task automatic reset_pulse();
    clear_masters();
    arst_i = 0;
    #2;
    arst_i = 1;
  endtask

  initial begin
    arst_i  = 0;
    m0_adr  = 5'd0;  m0_dat = 32'h0;
    m1_adr  = 5'd2;  m1_dat = 32'h1111_2222;
    s_dat_i = 32'hCAFE_F00D;
    clear_masters();

    // Reset state
    #3;
    check("rst_stb", s_stb_o, 0);
    check("rst_cyc", s_cyc_o, 0);
    check("rst_ack", m0_ack_o | m1_ack_o | m0_err_o | m1_err_o, 0);
    step();
    arst_i = 1;

    // Single write from m0
    m0_adr = 5'h00; m0_dat = 32'hDEAD_BEEF; m0_we = 1; m0_stb = 1; m0_cyc = 1;
    #1;
    check("w_stb_idle", s_stb_o, 0);
    step();
    check("w_stb_gnt", s_stb_o, 1);
    check("w_dat", s_dat_o, 32'hDEAD_BEEF);
    check("w_we", s_we_o, 1);
    check("w_ack_pre", m0_ack_o, 0);
    s_ack_i = 1;
    #1;
    check("w_ack0", m0_ack_o, 1);
    check("w_ack1", m1_ack_o, 0);
    check("rdata", m0_dat_o, 32'hCAFE_F00D);
    step();
    clear_masters();
    #1;
    check("w_ack_end", m0_ack_o, 0);
    step();
    // Late ack while idle goes nowhere
    s_ack_i = 1;
    #1;
    check("idle_ack", m0_ack_o | m1_ack_o, 0);
    s_ack_i = 0;

    // Simultaneous requests alternate, starting with m0 after reset
    reset_pulse();
    m0_adr = 5'd1; m1_adr = 5'd2;
    for (int r = 0; r < 4; r++) begin
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      step();
      check($sformatf("alt%0d_adr", r), s_adr_o, (r % 2 == 0) ? 5'd1 : 5'd2);
      s_ack_i = 1;
      #1;
      check($sformatf("alt%0d_ack0", r), m0_ack_o, (r % 2 == 0) ? 1 : 0);
      check($sformatf("alt%0d_ack1", r), m1_ack_o, (r % 2 == 0) ? 0 : 1);
      step();
      clear_masters();
      step();
    end

    // m1 locks the bus for three transfers while m0 waits
    m1_cyc = 1; m1_stb = 1;
    step();
    m0_cyc = 1; m0_stb = 1;
    for (int t = 0; t < 3; t++) begin
      s_ack_i = 1;
      #1;
      check($sformatf("lock%0d_ack1", t), m1_ack_o, 1);
      check($sformatf("lock%0d_ack0", t), m0_ack_o, 0);
      step();
      s_ack_i = 0; m1_stb = 0;
      #1;
      check($sformatf("lock%0d_gap_adr", t), s_adr_o, 5'd2);
      check($sformatf("lock%0d_gap_stb", t), s_stb_o, 0);
      step();
      m1_stb = 1;
    end
    m1_cyc = 0; m1_stb = 0;
    #1;
    check("hand_still1", s_adr_o, 5'd2);
    step();
    check("hand_adr0", s_adr_o, 5'd1);
    check("hand_cyc0", s_cyc_o, 1);
    check("hand_stb0", s_stb_o, 1);
    step();
    clear_masters();
    step();

    // Slave never acks, TIMEOUT=16
    m0_cyc = 1; m0_stb = 1;
    step();
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("to16_err_c%0d", k), m0_err_o, (k == 16) ? 1 : 0);
      check($sformatf("to16_ack_c%0d", k), m0_ack_o, 0);
      if (k < 16) step();
    end
    step();
    check("to16_kill_stb", s_stb_o, 0);
    check("to16_kill_err", m0_err_o, 0);
    step();
    check("to16_restb", s_stb_o, 1);
    clear_masters();
    step();

    // TIMEOUT=4: ack on the 4th cycle wins, then a bare timeout
    reset_pulse();
    m0_cyc = 1; m0_stb = 1;
    step();
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("to4_err_c%0d", k), b_m0_err_o, 0);
      step();
    end
    s_ack_i = 1;
    #1;
    check("to4_coin_ack", b_m0_ack_o, 1);
    check("to4_coin_err", b_m0_err_o, 0);
    step();
    s_ack_i = 0;
    step(); step(); step();
    check("to4_plain_err", b_m0_err_o, 1);
    step();
    clear_masters();
    step();

    // Asynchronous reset while m1 owns the bus
    reset_pulse();
    m1_adr = 5'd2; m0_adr = 5'd1;
    m1_cyc = 1; m1_stb = 1; m1_we = 1;
    step();
    s_ack_i = 1;
    #1;
    check("ar_pre_ack1", m1_ack_o, 1);
    arst_i = 0;
    #1;
    check("ar_stb", s_stb_o, 0);
    check("ar_cyc", s_cyc_o, 0);
    check("ar_adr", s_adr_o, 0);
    check("ar_ack1", m1_ack_o, 0);
    s_ack_i = 0;
    m0_cyc = 1; m0_stb = 1;
    #1;
    arst_i = 1;
    step();
    check("ar_tie_adr", s_adr_o, 5'd1);
    check("ar_tie_cyc", s_cyc_o, 1);
    clear_masters();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning slave-ack wait limit in clock cycles (legal range 2..255).
REQ-002 The block SHALL have port wb_clk_i  input  1  clock; all state changes on its rising edge.
REQ-003 The block SHALL have port arst_i  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports m0_adr_i/m1_adr_i  input  5  master address.
REQ-005 The block SHALL have ports m0_dat_i/m1_dat_i  input  32  master write data.
REQ-006 The block SHALL have ports m0_dat_o/m1_dat_o  output  32  read data, both driven from s_dat_i.
REQ-007 The block SHALL have ports m0_we_i/m1_we_i, m0_stb_i/m1_stb_i, m0_cyc_i/m1_cyc_i  input  1  master write enable, strobe and cycle.
REQ-008 The block SHALL have ports m0_ack_o/m1_ack_o and m0_err_o/m1_err_o  output  1  per-master acknowledge and timeout error.
REQ-009 The block SHALL have ports s_adr_o (5), s_dat_o (32), s_we_o, s_stb_o, s_cyc_o (1)  output  forwarded to the shared slave.
REQ-010 The block SHALL have ports s_dat_i  input  32  slave read data, and s_ack_i  input  1  slave acknowledge.

Function
REQ-011 The block SHALL implement FSM states IDLE, GNT0, GNT1 and a 1-bit last-grant register (last).
REQ-012 In IDLE, the block SHALL move to GNT0 if only m0_cyc_i is high, GNT1 if only m1_cyc_i is high, and with both high to GNT0 if last=1 or GNT1 if last=0.
REQ-013 On entering GNTn, the block SHALL set last=n.
REQ-014 Grant SHALL be registered: the slave sees the first strobe no earlier than one cycle after the request.
REQ-015 In GNTn, the block SHALL drive s_adr_o, s_dat_o, s_we_o, s_cyc_o and s_stb_o combinationally from master n.
REQ-016 In IDLE, the block SHALL drive s_cyc_o=0, s_stb_o=0, s_we_o=0, s_adr_o=0 and s_dat_o=0.
REQ-017 In GNTn, the block SHALL set mn_ack_o=s_ack_i, and the non-granted master's ack_o and err_o SHALL be 0.
REQ-018 In GNTn, grant SHALL hold while mn_cyc_i=1, including across stb gaps and multiple transfers (bus lock).
REQ-019 When mn_cyc_i=0 in GNTn, the block SHALL go next cycle to the other GNT state if the other master's cyc is high, else to IDLE.
REQ-020 The block SHALL keep an 8-bit wait counter: cleared in IDLE, on s_ack_i=1, or when s_stb_o=0; incremented each GNT cycle with s_stb_o=1 and s_ack_i=0.
REQ-021 When the counter equals TIMEOUT-1 with s_ack_i=0, the block SHALL assert mn_err_o for exactly that cycle, force s_stb_o=0 in the following cycle, and clear the counter.
REQ-022 The master SHALL treat err as terminating the transfer; grant SHALL be kept until its cyc drops.
REQ-023 If s_ack_i and the timeout condition coincide, ack SHALL win: ack asserted, err not asserted.
REQ-024 A master dropping cyc mid-transfer SHALL release the bus per REQ-019; a late s_ack_i SHALL then be routed only by the new state (dropped in IDLE).

Reset
REQ-025 While arst_i=0, the block SHALL hold state=IDLE, last=1, counter=0, all *_ack_o and *_err_o=0, and all s_* outputs=0, independent of the clock.
REQ-026 Reset deassertion mid-transfer SHALL resume from IDLE; the first grant after reset SHALL go to m0 on a tie.

Verification
REQ-027 Scenario: reset, then m0 writes 0xDEADBEEF to adr 0x00 -> s_stb_o high one cycle after m0_cyc_i, m0_ack_o pulses once, m1_ack_o stays 0.
REQ-028 Scenario: m0 and m1 raise cyc in the same cycle, repeated 4 times -> grants alternate m0, m1, m0, m1.
REQ-029 Scenario: m1 holds cyc for 3 transfers while m0 requests -> m0 is granted only in the cycle after m1_cyc_i falls (direct GNT1->GNT0, no IDLE).
REQ-030 Scenario: slave never acks, TIMEOUT=16 -> granted master's err_o pulses on the 16th strobe cycle, s_stb_o is 0 the next cycle, and no ack is seen.
REQ-031 Scenario: ack and timeout in the same cycle (TIMEOUT=4, ack on the 4th cycle) -> ack=1 and err=0.
REQ-032 Scenario: arst_i pulled low during GNT1 -> all outputs are 0 immediately (asynchronously); after release with both requesting, m0 is granted.
